// File: rtl/pa_riscv.sv
// Shared RISC-V datapath definitions: ALU operation encoding and the
// multiply-sequencer state type used by the datapath arbiter.
package pa_riscv;

   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_SLT = 4'd2,
      ALU_AND = 4'd3,
      ALU_OR  = 4'd4,
      ALU_XOR = 4'd5
   } alu_op_e;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier producing the low WIDTH bits of A*B, borrowing the
// shared ALU's ADD on the steps whose multiplier bit is set.
module alu_mul_sequencer
   import pa_riscv::*;
#(
   parameter int WIDTH      = 32,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_multiplicand,
   input  logic [WIDTH-1:0] i_multiplier,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product,
   output logic             o_aluReq,
   input  logic             i_aluGrant,
   output logic [WIDTH-1:0] o_aluA,
   output logic [WIDTH-1:0] o_aluB,
   output logic [3:0]       o_aluOp,
   input  logic [WIDTH-1:0] i_aluResult
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   seq_state_e       state, state_next;
   logic [WIDTH-1:0] acc, mcand, mplier, product;
   logic [WIDTH-1:0] acc_step;
   logic [CW-1:0]    count;
   logic             alu_req, advance, last_step;

   // NOTE: every signal gets a default before the case so no path leaves
   // a variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      alu_req    = 1'b0;
      advance    = 1'b0;
      last_step  = 1'b0;
      acc_step   = acc;
      unique case (state)
         SEQ_IDLE: begin
            if (i_start)
               state_next = (i_multiplier == '0) ? SEQ_DONE : SEQ_RUN;
         end
         SEQ_RUN: begin
            alu_req   = mplier[0];
            // A set bit must wait for the grant; a clear bit never needs the ALU.
            advance   = !mplier[0] || i_aluGrant;
            acc_step  = mplier[0] ? i_aluResult : acc;
            last_step = (count == LAST) || (EARLY_EXIT && ((mplier >> 1) == '0));
            if (advance && last_step)
               state_next = SEQ_DONE;
         end
         SEQ_DONE: state_next = SEQ_IDLE;
         default:  state_next = SEQ_IDLE;
      endcase
   end

   // NOTE: reset is synchronous (checked inside the clocked block) and all
   // state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state   <= SEQ_IDLE;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         count   <= '0;
         product <= '0;
      end else begin
         state <= state_next;
         if (state == SEQ_IDLE && i_start) begin
            mcand  <= i_multiplicand;
            mplier <= i_multiplier;
            acc    <= '0;
            count  <= '0;
            if (i_multiplier == '0)
               product <= '0;
         end else if (state == SEQ_RUN && advance) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (last_step)
               product <= acc_step;
         end
      end
   end

   assign o_busy    = (state != SEQ_IDLE);
   assign o_done    = (state == SEQ_DONE);
   assign o_product = product;
   assign o_aluReq  = alu_req;
   assign o_aluA    = acc;
   assign o_aluB    = mcand;
   assign o_aluOp   = ALU_ADD;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares on every o_done pulse.
module tb_alu_mul_sequencer;
   import pa_riscv::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] mcand_in = '0;
   logic [31:0] mplier_in = '0;
   logic        busy, done, alu_req;
   logic [31:0] product, alu_a, alu_b, alu_res;
   logic [3:0]  alu_op;
   logic        grant = 1'b1;
   logic [31:0] junk = 32'hDEAD_BEEF;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int stall_budget = 0;
   bit rand_grant = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] prod;
      int          start_cyc;
   } op_t;
   op_t sb[$];

   alu_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (start),
      .i_multiplicand (mcand_in),
      .i_multiplier   (mplier_in),
      .o_busy         (busy),
      .o_done         (done),
      .o_product      (product),
      .o_aluReq       (alu_req),
      .i_aluGrant     (grant),
      .o_aluA         (alu_a),
      .o_aluB         (alu_b),
      .o_aluOp        (alu_op),
      .i_aluResult    (alu_res)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] alu_model(input logic [31:0] a, b, input logic [3:0] op);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         default: return a ^ b;
      endcase
   endfunction

   // When the core owns the ALU the sequencer sees unrelated data.
   assign alu_res = grant ? alu_model(alu_a, alu_b, alu_op) : junk;

   function automatic int msb_index(input logic [31:0] v);
      int m = -1;
      for (int i = 0; i < 32; i++) if (v[i]) m = i;
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      #1;
      junk = $urandom;
      if (stall_budget > 0 && alu_req) begin
         grant = 1'b0;
         stall_budget--;
      end else if (rand_grant) begin
         grant = ($urandom_range(0, 3) != 0);
      end else begin
         grant = 1'b1;
      end
   end

   int granted = 0;
   int stalls = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         granted = 0;
         stalls  = 0;
      end else begin
         if (alu_req && grant)  granted++;
         if (alu_req && !grant) stalls++;
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: product 0x%08h with nothing outstanding", product);
            end else begin
               op_t e;
               int  exp_lat;
               e = sb.pop_front();
               exp_lat = (e.b == 0) ? 1 : msb_index(e.b) + 2 + stalls;
               check("product", product, e.prod);
               check("latency", 32'(cyc - e.start_cyc), 32'(exp_lat));
               check("alu_adds", 32'(granted), 32'($countones(e.b)));
               check("busy_at_done", {31'd0, busy}, 32'd1);
            end
            granted = 0;
            stalls  = 0;
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b);
      int          n;
      logic [31:0] p;
      n = 0;
      while (busy && n < 200) begin
         wait_cycles(1);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_wait: busy still 1 after %0d cycles", n);
      end
      p = a * b;
      mcand_in  = a;
      mplier_in = b;
      start     = 1'b1;
      sb.push_back('{a, b, p, cyc});
      wait_cycles(1);
      start = 1'b0;
   endtask

   initial begin
      int n;
      wait_cycles(2);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_product", product, 32'd0);
      check("reset_alu_req", {31'd0, alu_req}, 32'd0);
      rst_n = 1'b1;
      wait_cycles(1);

      do_op(32'd3, 32'd5);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op(32'h1234, 32'd0);
      stall_budget = 3;
      do_op(32'd7, 32'd3);

      // Second start lands while the first operation is still in RUN.
      do_op(32'd2, 32'd2);
      mcand_in  = 32'd9;
      mplier_in = 32'd9;
      start     = 1'b1;
      wait_cycles(1);
      start = 1'b0;
      do_op(32'd9, 32'd9);
      do_op(32'h8000_0000, 32'h8000_0001);

      // Reset in the middle of RUN discards the operation.
      do_op(32'd100, 32'hF0);
      wait_cycles(2);
      rst_n = 1'b0;
      sb.delete();
      wait_cycles(1);
      rst_n = 1'b1;
      check("midrun_reset_busy", {31'd0, busy}, 32'd0);
      check("midrun_reset_product", product, 32'd0);
      check("midrun_reset_done", {31'd0, done}, 32'd0);
      wait_cycles(20);

      rand_grant = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if (i % 10 == 3) b = '0;
         do_op(a, b);
      end

      n = 0;
      while (sb.size() > 0 && n < 2000) begin
         wait_cycles(1);
         n++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      end
      wait_cycles(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Iterative shift-add multiplier that computes the low 32 bits of a 32x32 product by borrowing the shared ALU for its ADD operation.
- Sits beside the ALU in the datapath and requests the ALU only on cycles that need an add.
- A top-level grant decides whether the core or the sequencer drives the ALU inputs that cycle.
- Start/busy/done handshake toward the requester.

Parameters:
- WIDTH, 32, operand/product width; must match the ALU data width.
- EARLY_EXIT, 1, when 1 the operation finishes as soon as the remaining multiplier bits are all zero; when 0 it always runs WIDTH RUN steps.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_start  input  1  start request; sampled only in IDLE.
- i_multiplicand  input  WIDTH  operand A, captured on the accepted start.
- i_multiplier  input  WIDTH  operand B, captured on the accepted start.
- o_busy  output  1  high in RUN and DONE.
- o_done  output  1  one-cycle pulse; product valid.
- o_product  output  WIDTH  low WIDTH bits of A*B; held until the next accepted start.
- o_aluReq  output  1  sequencer needs the ALU this cycle.
- i_aluGrant  input  1  ALU inputs are driven from o_alu* this cycle (combinational, same cycle).
- o_aluA  output  WIDTH  ALU operand a = accumulator.
- o_aluB  output  WIDTH  ALU operand b = shifted multiplicand.
- o_aluOp  output  4  ALU operation; constant ADD from the shared package.
- i_aluResult  input  WIDTH  ALU combinational result.

Behaviour:
- Reset (i_rst_n=0 at an edge): state=IDLE; acc, mcand, mplier, count and o_product all 0; o_done=0; o_busy=0; o_aluReq=0. Reset mid-operation abandons the operation; no o_done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - On i_start=1: mcand<=i_multiplicand, mplier<=i_multiplier, acc<=0, count<=0.
  - Next state is DONE if i_multiplier==0 (o_product<=0), otherwise RUN.
- RUN, one multiplier bit per step:
  - o_aluReq = mplier[0].
  - If mplier[0]=1 and i_aluGrant=0, the step stalls: no register changes and the request stays asserted.
  - Otherwise the step advances:
    - acc<=i_aluResult if mplier[0]=1, else acc is unchanged.
    - mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1.
  - The step is final when count==WIDTH-1, or when EARLY_EXIT=1 and (mplier>>1)==0.
  - On the final step: o_product<=updated acc and next state is DONE.
- DONE: o_done=1 for exactly this cycle; next state IDLE.
- o_busy is 1 in RUN and DONE; i_start is ignored while busy.
- Back-to-back operation: a start in the IDLE cycle immediately after DONE is accepted.
- Arithmetic is modulo 2^WIDTH: overflow is discarded and operands are treated as unsigned. The low WIDTH bits are identical for signed operands.
- o_aluA, o_aluB and o_aluOp are driven continuously. They are meaningful only when o_aluReq=1.
- Latency, with grant always present and EARLY_EXIT=1:
  - o_done arrives (msb_index(B)+2) cycles after the start cycle.
  - For B==0, o_done arrives 1 cycle after the start cycle.
  - Each stalled cycle adds 1.
- o_product updates only on the final RUN step, or on a start with B==0. It holds otherwise.

Decomposition:
- pa_riscv already holds the 4-bit ALU operation encoding (ADD, SUB, SLT, AND, OR, XOR); o_aluOp uses ADD from it.
- Add the sequencer state enum (IDLE, RUN, DONE) to pa_riscv so the top-level arbiter and the bench can reference it.
- No sub-module. The ALU stays a sibling instance, and the grant mux lives in the datapath top.

Test Plan:
- A=3, B=5, grant tied 1, start at cycle 0 -> o_aluReq high on RUN cycles 1 and 3, low on cycle 2; o_done at cycle 4; o_product=15; o_busy high cycles 1–4.
- A=0xFFFFFFFF, B=0xFFFFFFFF, grant 1 -> 32 RUN cycles; o_done at cycle 33; o_product=0x00000001.
- A=0x1234, B=0 -> no ALU request; o_done at cycle 1; o_product=0.
- A=7, B=3, grant held 0 for 3 cycles at the first request -> registers frozen during the stall; o_done delayed by exactly 3 cycles (cycle 6); o_product=21.
- Start with A=2, B=2, then i_start pulsed again with A=9, B=9 during RUN -> second start ignored; o_product=4; a new start in the following IDLE yields 81.
- i_rst_n low for 1 cycle mid-RUN of A=100, B=0xF0 -> next cycle IDLE, o_busy=0, o_product=0, no o_done pulse.
